blake_msg_loader: RTL and testbench
===================================

# blake_msg_loader

Upstream feeder for the BLAKE-512 compression controller. Collects one 1024-bit message block as sixteen 64-bit words over a valid/ready stream and maintains the 128-bit message bit counter t. It fires a one-cycle `ena` pulse to the round controller, then holds block and counter stable until the controller's `clr_all` releases it. Padding is done by the host; this block only counts bits and sequences blocks.

## Interface
- `WORD_W`, default 64: input word width; only 64 is supported.
- `BLK_WORDS`, default 16: words per block; only 16 is supported.
- `clk` in 1: clock.
- `rstb` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: loader can accept a word.
- `in_data` in 64: message word, big-endian BLAKE word M[i].
- `in_msgbits` in 11: message (non-padding) bits in this block, 0..1024; sampled with word 15.
- `in_last` in 1: this block is the final block of the message; sampled with word 15.
- `ctrl_finalize` in 1: from controller, compression finishing.
- `clr_all` in 1: from controller, block consumed.
- `ena` out 1: start pulse to controller.
- `m_block` out 1024: word i at bits [64*(15-i)+63 : 64*(15-i)].
- `t_cnt` out 128: counter value for the current block.
- `last_blk` out 1: current block is final.
- `msg_done` out 1: one-cycle pulse, final block compressed.

## Operation
- States:
  - LOAD: `in_ready`=1. Each handshake (`in_valid`&&`in_ready`) writes `in_data` into slot `widx` and does `widx`+1.
    - At `widx`=15 the handshake also latches `in_last` into `last_blk` and updates the counter. Then go to START.
  - START: one cycle, `ena`=1. Go to WAIT.
  - WAIT: `in_ready`=0. Go to LOAD on `clr_all`.
- Counter rule:
  - Internal accumulator `t_acc` (128 b) updates `t_acc <= t_acc + in_msgbits`, modulo 2^128 (wrap, no saturation).
  - `t_cnt <= (in_msgbits==0) ? 0 : t_acc + in_msgbits`. A pure-padding block carries counter 0, per BLAKE.
- On `clr_all` in WAIT with `last_blk`=1: `t_acc` goes to 0 and `last_blk` clears, ready for a new message.
- `msg_done`: registered, asserted for one cycle the cycle after `ctrl_finalize` is seen in WAIT with `last_blk`=1.
- Ignored inputs:
  - `ctrl_finalize` and `clr_all` outside WAIT.
  - `in_valid` while `in_ready`=0. The word is not consumed; the host must hold it.
- `m_block`, `t_cnt` and `last_blk` are stable from START until the cycle after `clr_all`.
- `in_msgbits` > 1024 is illegal; behaviour is unspecified beyond 11-bit modular addition.

## Timing
- Reset values:
  - State LOAD, `widx`=0, `in_ready`=1.
  - `ena`=0, `m_block`=0, `t_cnt`=0, `t_acc`=0, `last_blk`=0, `msg_done`=0.
- `ena` is a registered output, high exactly the cycle after the 16th handshake.
- `in_ready` is a registered decode of state. Once accepted, the 16 words can stream back-to-back at one per cycle.
- Block turnaround: `in_ready` returns high the cycle after `clr_all` is sampled.
- Reset mid-block or mid-compression:
  - Aborts everything.
  - Partial words are discarded and `t_acc` is lost.
  - No `ena` or `msg_done` is emitted.

## Structure
- Shared package `blake_pkg`:
  - `WORD_W`=64, `BLK_WORDS`=16, `CNT_W`=128.
  - State encoding `ld_load`/`ld_start`/`ld_wait` (2 bits).
  - Block/counter width constants shared with the controller and round datapath.
- One sub-module is natural: `blake_t_counter`, the 128-bit accumulator with the zero-block rule and message-restart clear.
- Everything else is one FSM plus a 16×64 word register file with one-hot write by `widx`.

## Test plan
- Single block, words 0x0000_0000_0000_0000..0x0F (i = word index), `in_msgbits`=576, `in_last`=1:
  - `ena` pulses once the cycle after word 15.
  - `m_block[1023:960]`=0, `m_block[63:0]`=0xF.
  - `t_cnt`=576, `last_blk`=1.
  - After `ctrl_finalize`, `msg_done` pulses once.
- Two-block message (1024, then 0 bits, last):
  - First block `t_cnt`=1024.
  - Second block `t_cnt`=0.
  - After the second `clr_all`, `t_acc`=0.
- Backpressure:
  - Hold `in_valid`=1 with a new word during WAIT for 50 cycles: `in_ready`=0 throughout and the word is not consumed.
  - After `clr_all`, the word is accepted as `widx`=0.
- Wrap: preload `t_acc`=2^128-256 via a block sequence or force, then load a block with `in_msgbits`=512 → `t_cnt`=256.
- Reset mid-load: deassert `rstb` after 7 words → all outputs at reset values, and a subsequent full block gives `t_cnt`=`in_msgbits`.
- Spurious `clr_all`/`ctrl_finalize` pulses in LOAD do not change `widx`, `t_acc` or `msg_done`.

Source files
------------

// File: rtl/blake_pkg.sv
// Shared BLAKE-512 constants and the message-loader state encoding.
// Width constants are common to the loader, round controller and datapath.
package blake_pkg;

  localparam int WORD_W    = 64;
  localparam int BLK_WORDS = 16;
  localparam int CNT_W     = 128;
  localparam int BLK_W     = WORD_W * BLK_WORDS;
  localparam int MSGBITS_W = 11;

  typedef enum logic [1:0] {
    ld_load  = 2'd0,
    ld_start = 2'd1,
    ld_wait  = 2'd2
  } ld_state_t;

endpackage

// File: rtl/blake_t_counter.sv
// 128-bit BLAKE message bit counter: running accumulator plus per-block t value.
// A block carrying zero message bits reports t = 0; restart clears the message.
module blake_t_counter
  import blake_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 load,
  input  logic [MSGBITS_W-1:0] msgbits,
  input  logic                 restart,
  output logic [CNT_W-1:0]     t_cnt
);

  logic [CNT_W-1:0] t_acc;
  logic [CNT_W-1:0] t_sum;

  // Modular add; the accumulator wraps at 2^128 rather than saturating.
  assign t_sum = t_acc + CNT_W'(msgbits);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      t_acc <= '0;
      t_cnt <= '0;
    end else if (restart) begin
      t_acc <= '0;
    end else if (load) begin
      t_acc <= t_sum;
      t_cnt <= (msgbits == '0) ? '0 : t_sum;
    end
  end

endmodule

// File: rtl/blake_msg_loader.sv
// Collects sixteen 64-bit words into one BLAKE-512 block, pulses ena to the
// round controller, then holds block/counter until clr_all releases it.
//
// Input handshake: a word transfers on a rising edge where in_valid and
// in_ready are both high; the host holds in_data/in_msgbits/in_last stable
// while in_valid is high and in_ready is low.
module blake_msg_loader #(
  parameter int WORD_W    = blake_pkg::WORD_W,
  parameter int BLK_WORDS = blake_pkg::BLK_WORDS
) (
  input  logic                        clk,
  input  logic                        rstb,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W-1:0]           in_data,
  input  logic [10:0]                 in_msgbits,
  input  logic                        in_last,
  input  logic                        ctrl_finalize,
  input  logic                        clr_all,
  output logic                        ena,
  output logic [WORD_W*BLK_WORDS-1:0] m_block,
  output logic [127:0]                t_cnt,
  output logic                        last_blk,
  output logic                        msg_done,
  output blake_pkg::ld_state_t        fsm_state
);
  import blake_pkg::*;

  localparam int WIDX_W = $clog2(BLK_WORDS);

  ld_state_t         state;
  ld_state_t         state_next;
  logic [WIDX_W-1:0] widx;
  logic [WORD_W-1:0] words [BLK_WORDS];
  logic              hs;
  logic              blk_done;
  logic              in_wait;
  logic              restart;

  assign hs       = in_valid && in_ready;
  assign blk_done = hs && (widx == WIDX_W'(BLK_WORDS - 1));
  assign in_wait  = (state == ld_wait);
  assign restart  = in_wait && clr_all && last_blk;
  assign fsm_state = state;

  always_comb begin
    state_next = state;
    unique case (state)
      ld_load:  if (blk_done) state_next = ld_start;
      ld_start: state_next = ld_wait;
      ld_wait:  if (clr_all) state_next = ld_load;
      default:  state_next = ld_load;
    endcase
  end

  // in_ready and ena are registered decodes of the next state.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= ld_load;
      in_ready <= 1'b1;
      ena      <= 1'b0;
      msg_done <= 1'b0;
      widx     <= '0;
      last_blk <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next == ld_load);
      ena      <= (state_next == ld_start);
      msg_done <= in_wait && ctrl_finalize && last_blk;
      if (hs)
        widx <= widx + 1'b1;
      if (blk_done)
        last_blk <= in_last;
      else if (restart)
        last_blk <= 1'b0;
    end
  end

  // Word register file with one-hot write; word i lands in the i-th
  // 64-bit lane counting down from the top of m_block.
  for (genvar i = 0; i < BLK_WORDS; i++) begin : g_words
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb)
        words[i] <= '0;
      else if (hs && (widx == WIDX_W'(i)))
        words[i] <= in_data;
    end
    assign m_block[WORD_W*(BLK_WORDS-1-i) +: WORD_W] = words[i];
  end

  blake_t_counter u_t_counter (
    .clk     (clk),
    .rstb    (rstb),
    .load    (blk_done),
    .msgbits (in_msgbits),
    .restart (restart),
    .t_cnt   (t_cnt)
  );

endmodule

// File: tb/tb_blake_msg_loader.sv
// Self-checking bench for blake_msg_loader: randomized blocks against a bit-count
// model, with a scoreboard queue popped by a monitor on ena / msg_done.
module tb_blake_msg_loader;
  import blake_pkg::*;

  localparam int BW = 1024;
  localparam int EW = 32 + BW + 128 + 1;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_data = '0;
  logic [10:0]   in_msgbits = '0;
  logic          in_last = 1'b0;
  logic          ctrl_finalize = 1'b0;
  logic          clr_all = 1'b0;
  logic          ena;
  logic [BW-1:0] m_block;
  logic [127:0]  t_cnt;
  logic          last_blk;
  logic          msg_done;
  ld_state_t     fsm_state;

  blake_msg_loader dut (
    .clk           (clk),
    .rstb          (rstb),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_msgbits    (in_msgbits),
    .in_last       (in_last),
    .ctrl_finalize (ctrl_finalize),
    .clr_all       (clr_all),
    .ena           (ena),
    .m_block       (m_block),
    .t_cnt         (t_cnt),
    .last_blk      (last_blk),
    .msg_done      (msg_done),
    .fsm_state     (fsm_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];    // {ena cycle, block, t, last}
  int            done_q[$];   // expected msg_done cycles
  int            checks = 0;
  int            errors = 0;

  // Reference model: total message bits so far and the pending last flag.
  logic [127:0]  m_acc = '0;
  logic          m_last = 1'b0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic [EW-1:0] mon_e;
  int            mon_d;

  always @(negedge clk) begin
    if (rstb && ena) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ena_unexpected: ena=1 at cycle %0d, required 0 (no block pending)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ena_cycle", 128'(cyc), 128'(mon_e[EW-1 -: 32]));
        chk("t_cnt", t_cnt, mon_e[128:1]);
        chk("last_blk", 128'(last_blk), 128'(mon_e[0]));
        checks++;
        if (m_block !== mon_e[BW+128:129]) begin
          errors++;
          for (int i = 0; i < 16; i++) begin
            if (m_block[64*(15-i) +: 64] !== mon_e[129 + 64*(15-i) +: 64]) begin
              $display("FAIL m_block: word %0d got %0h required %0h", i,
                       m_block[64*(15-i) +: 64], mon_e[129 + 64*(15-i) +: 64]);
              break;
            end
          end
        end
      end
    end
    if (rstb && msg_done) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL msg_done_unexpected: msg_done=1 at cycle %0d, required 0", cyc);
      end else begin
        mon_d = done_q.pop_front();
        chk("msg_done_cycle", 128'(cyc), 128'(mon_d));
      end
    end
  end

  // ---------------- driver tasks (all start and end on a negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Idle cycles in LOAD with spurious controller strobes that must be ignored.
  task automatic gap();
    int n = $urandom_range(1, 3);
    repeat (n) begin
      clr_all       = 1'($urandom_range(0, 1));
      ctrl_finalize = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    clr_all       = 1'b0;
    ctrl_finalize = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] d, input logic [10:0] mb, input logic lst,
                           input bit do_push, input logic [EW-1:0] e);
    int t = 0;
    logic [EW-1:0] ee;
    in_valid   = 1'b1;
    in_data    = d;
    in_msgbits = mb;
    in_last    = lst;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=0 for %0d cycles, required 1", t);
    end else if (do_push) begin
      ee = e;
      ee[EW-1 -: 32] = 32'(cyc + 1);
      exp_q.push_back(ee);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] w[16], input logic [10:0] mb,
                            input logic lst, input bit gaps);
    logic [BW-1:0]  blk = '0;
    logic [127:0]   t;
    logic [EW-1:0]  e;
    for (int i = 0; i < 16; i++) blk = {blk[BW-65:0], w[i]};
    t = (mb == 11'd0) ? 128'd0 : m_acc + 128'(mb);
    e = {32'd0, blk, t, lst};
    for (int i = 0; i < 16; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) gap();
      send_word(w[i], mb, lst, i == 15, e);
    end
    m_acc  = m_acc + 128'(mb);
    m_last = lst;
  endtask

  task automatic finish_block(input bit fin);
    int t = 0;
    while (!ena && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ena) begin
      checks++;
      errors++;
      $display("FAIL ena_timeout: ena=0 for %0d cycles, required 1", t);
    end
    idle(1 + $urandom_range(0, 3));
    if (fin) begin
      ctrl_finalize = 1'b1;
      if (m_last) done_q.push_back(cyc + 1);
      @(negedge clk);
      ctrl_finalize = 1'b0;
      idle($urandom_range(0, 2));
    end
    clr_all = 1'b1;
    @(negedge clk);
    clr_all = 1'b0;
    if (m_last) begin
      m_acc  = '0;
      m_last = 1'b0;
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    chk({tag, "_ena"}, 128'(ena), 128'd0);
    chk({tag, "_m_block_zero"}, 128'(|m_block), 128'd0);
    chk({tag, "_t_cnt"}, t_cnt, 128'd0);
    chk({tag, "_last_blk"}, 128'(last_blk), 128'd0);
    chk({tag, "_msg_done"}, 128'(msg_done), 128'd0);
    chk({tag, "_state"}, 128'(fsm_state), 128'(ld_load));
  endtask

  function automatic logic [10:0] rand_mb();
    int r = $urandom_range(0, 4);
    if (r == 0) return 11'd0;
    if (r == 1) return 11'd1024;
    return 11'($urandom_range(1, 1023));
  endfunction

  // ---------------- main sequence ----------------
  logic [63:0] w[16];
  logic [63:0] held;
  int          bp_bad;

  initial begin
    idle(3);
    reset_checks("reset");
    rstb = 1'b1;
    idle(2);

    // Single block with word i = i, 576 bits, final.
    for (int i = 0; i < 16; i++) w[i] = 64'(i);
    send_block(w, 11'd576, 1'b1, 1'b0);
    chk("single_t_cnt", t_cnt, 128'd576);
    chk("single_word0", m_block[1023:960], 128'd0);
    chk("single_word15", m_block[63:0], 128'hF);
    chk("single_last", 128'(last_blk), 128'd1);
    finish_block(1'b1);

    // Two-block message: full block, then a pure-padding final block.
    for (int i = 0; i < 16; i++) w[i] = {$urandom, $urandom};
    send_block(w, 11'd1024, 1'b0, 1'b1);
    chk("two_blk1_t_cnt", t_cnt, 128'd1024);
    finish_block(1'b0);
    for (int i = 0; i < 16; i++) w[i] = {$urandom, $urandom};
    send_block(w, 11'd0, 1'b1, 1'b1);
    chk("two_blk2_t_cnt", t_cnt, 128'd0);
    finish_block(1'b1);

    // Fresh message after restart, with spurious strobes while loading.
    for (int i = 0; i < 16; i++) w[i] = {$urandom, $urandom};
    send_block(w, 11'd300, 1'b0, 1'b1);
    chk("restart_t_cnt", t_cnt, 128'd300);

    // Backpressure: a word offered during WAIT must not be consumed.
    idle(2);
    held = {$urandom, $urandom};
    bp_bad = 0;
    in_valid = 1'b1;
    in_data  = held;
    repeat (50) begin
      if (in_ready) bp_bad++;
      @(negedge clk);
    end
    chk("backpressure_ready_low", 128'(bp_bad), 128'd0);
    clr_all = 1'b1;
    @(negedge clk);
    clr_all = 1'b0;
    chk("turnaround_ready", 128'(in_ready), 128'd1);
    for (int i = 0; i < 16; i++) w[i] = {$urandom, $urandom};
    w[0] = held;
    send_block(w, 11'd200, 1'b1, 1'b0);
    chk("backpressure_t_cnt", t_cnt, 128'd500);
    finish_block(1'b1);

    // Randomized message traffic.
    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < 16; i++) w[i] = {$urandom, $urandom};
      send_block(w, rand_mb(), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      finish_block(1'($urandom_range(0, 1)));
    end
    if (m_last) begin
      for (int i = 0; i < 16; i++) w[i] = {$urandom, $urandom};
      send_block(w, rand_mb(), 1'b1, 1'b0);
      finish_block(1'b1);
    end else begin
      for (int i = 0; i < 16; i++) w[i] = {$urandom, $urandom};
      send_block(w, rand_mb(), 1'b1, 1'b0);
      finish_block(1'b1);
    end

    // Counter wrap at 2^128.
    force dut.u_t_counter.t_acc = {{120{1'b1}}, 8'h00};
    m_acc = {{120{1'b1}}, 8'h00};
    for (int i = 0; i < 16; i++) w[i] = {$urandom, $urandom};
    send_block(w, 11'd512, 1'b1, 1'b0);
    chk("wrap_t_cnt", t_cnt, 128'd256);
    release dut.u_t_counter.t_acc;
    finish_block(1'b1);

    // Reset after 7 words discards the partial block and the count.
    for (int i = 0; i < 16; i++) w[i] = {$urandom, $urandom};
    send_block(w, 11'd100, 1'b0, 1'b0);
    finish_block(1'b0);
    for (int i = 0; i < 7; i++) send_word({$urandom, $urandom}, 11'd64, 1'b0, 1'b0, '0);
    rstb = 1'b0;
    m_acc  = '0;
    m_last = 1'b0;
    @(negedge clk);
    reset_checks("midload");
    rstb = 1'b1;
    idle(1);
    for (int i = 0; i < 16; i++) w[i] = {$urandom, $urandom};
    send_block(w, 11'd777, 1'b1, 1'b1);
    chk("post_reset_t_cnt", t_cnt, 128'd777);
    finish_block(1'b1);

    idle(10);
    chk("exp_q_drained", 128'(exp_q.size()), 128'd0);
    chk("done_q_drained", 128'(done_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
